// File: rtl/relogio_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | relogio_ctrl                                                             |
// | 1 Hz prescaler, button debounce and run/set sequencing for the clock.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module relogio_ctrl #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       maqs_clock,
  input  logic       maqs_reset,
  input  logic       btn_modo,
  input  logic       btn_inc,
  input  logic       inc_minuto_in,
  input  logic       inc_hora_in,
  output logic       tick_1hz,
  output logic       seg_en,
  output logic       min_en,
  output logic       hora_en,
  output logic       seg_clr,
  output logic [1:0] modo,
  output logic       blink
);

  localparam int c_PW = $clog2(CLK_HZ);
  localparam int c_DW = $clog2(DEB_CYCLES + 1);
  localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(CLK_HZ - 1);
  localparam logic [c_PW-1:0] c_PRESC_HALF = c_PW'(CLK_HZ / 2);
  localparam logic [c_DW-1:0] c_DEB_LAST = c_DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_HORA = 2'b01,
    S_MIN  = 2'b10
  } state_t;

  state_t          r_state;
  logic [c_PW-1:0] r_presc;
  logic            r_tick;
  logic            r_seg_clr;
  logic [1:0]      w_btn_raw;
  logic [1:0]      w_press;
  logic            w_inc_ok;

  assign w_btn_raw = {btn_inc, btn_modo};

  // Index 0 is the mode button, index 1 the increment button.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic            r_s1;
      logic            r_s2;
      logic            r_deb;
      logic            r_deb_d;
      logic            r_press;
      logic [c_DW-1:0] r_cnt;

      always_ff @(posedge maqs_clock or negedge maqs_reset) begin
        if (!maqs_reset) begin
          r_s1    <= 1'b0;
          r_s2    <= 1'b0;
          r_deb   <= 1'b0;
          r_deb_d <= 1'b0;
          r_press <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_s1    <= w_btn_raw[gi];
          r_s2    <= r_s1;
          if (r_s2 != r_deb) begin
            if (r_cnt == c_DEB_LAST) begin
              r_deb <= r_s2;
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + c_DW'(1);
            end
          end else begin
            r_cnt <= '0;
          end
          r_deb_d <= r_deb;
          r_press <= r_deb & ~r_deb_d;
        end
      end

      assign w_press[gi] = r_press;
    end
  endgenerate

  always_ff @(posedge maqs_clock or negedge maqs_reset) begin
    if (!maqs_reset) begin
      r_state   <= S_RUN;
      r_presc   <= '0;
      r_tick    <= 1'b0;
      r_seg_clr <= 1'b0;
    end else begin
      r_seg_clr <= 1'b0;
      r_tick    <= (r_presc == c_PRESC_MAX);
      r_presc   <= (r_presc == c_PRESC_MAX) ? '0 : r_presc + c_PW'(1);
      case (r_state)
        S_RUN:  if (w_press[0]) r_state <= S_HORA;
        S_HORA: if (w_press[0]) r_state <= S_MIN;
        S_MIN: begin
          // Leaving set mode restarts the second so the first tick is a full period away.
          if (w_press[0]) begin
            r_state   <= S_RUN;
            r_seg_clr <= 1'b1;
            r_presc   <= '0;
            r_tick    <= 1'b0;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  // A mode press in the same cycle swallows the increment.
  assign w_inc_ok = w_press[1] & ~w_press[0];

  always_comb begin
    seg_en  = 1'b0;
    min_en  = 1'b0;
    hora_en = 1'b0;
    case (r_state)
      S_RUN: begin
        seg_en  = r_tick;
        min_en  = r_tick & inc_minuto_in;
        hora_en = r_tick & inc_minuto_in & inc_hora_in;
      end
      S_HORA:  hora_en = w_inc_ok;
      S_MIN:   min_en  = w_inc_ok;
      default: ;
    endcase
  end

  assign tick_1hz = r_tick;
  assign seg_clr  = r_seg_clr;
  assign modo     = r_state;
  assign blink    = (r_state == S_RUN) || (r_presc < c_PRESC_HALF);

endmodule
`default_nettype wire

// File: tb/tb_relogio_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_relogio_ctrl                                                          |
// | Directed bench for relogio_ctrl with a cycle-level reference model.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_relogio_ctrl;

  localparam int CLK_HZ = 10;
  localparam int DEB    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_m = 1'b0;
  logic       btn_i = 1'b0;
  logic       im = 1'b0;
  logic       ih = 1'b0;
  logic       tick_1hz, seg_en, min_en, hora_en, seg_clr, blink;
  logic [1:0] modo;

  relogio_ctrl #(.CLK_HZ(CLK_HZ), .DEB_CYCLES(DEB)) dut (
    .maqs_clock(clk), .maqs_reset(rst_n), .btn_modo(btn_m), .btn_inc(btn_i),
    .inc_minuto_in(im), .inc_hora_in(ih), .tick_1hz(tick_1hz), .seg_en(seg_en),
    .min_en(min_en), .hora_en(hora_en), .seg_clr(seg_clr), .modo(modo), .blink(blink)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Reference model: second counter, mode number, per-button sample history.
  int m_presc, m_md;
  bit m_tick, m_clr;
  bit s1[2], s2[2], lvl[2], lvlp[2], prs[2];
  int run[2];

  // Tallies for the hand-computed expectations.
  int n_seg, n_min, n_hora, n_clr, n_blink0, n_modo_nz;
  int first_modo1, clr_cyc, seg_after_clr;
  int tick_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_presc = 0; m_md = 0; m_tick = 0; m_clr = 0;
    for (int b = 0; b < 2; b++) begin
      s1[b] = 0; s2[b] = 0; lvl[b] = 0; lvlp[b] = 0; prs[b] = 0; run[b] = 0;
    end
  endtask

  task automatic model_edge();
    bit mp, nt, nc, np_prs;
    int np;
    bit raw[2];
    raw[0] = btn_m;
    raw[1] = btn_i;
    mp = prs[0];
    nt = (m_presc == CLK_HZ - 1);
    np = (m_presc + 1) % CLK_HZ;
    nc = 0;
    if (mp) begin
      if (m_md == 2) begin
        m_md = 0; np = 0; nt = 0; nc = 1;
      end else begin
        m_md = m_md + 1;
      end
    end
    m_presc = np; m_tick = nt; m_clr = nc;
    for (int b = 0; b < 2; b++) begin
      np_prs  = lvl[b] && !lvlp[b];
      lvlp[b] = lvl[b];
      if (s2[b] != lvl[b]) begin
        run[b]++;
        if (run[b] == DEB) begin
          lvl[b] = s2[b];
          run[b] = 0;
        end
      end else begin
        run[b] = 0;
      end
      s2[b]  = s1[b];
      s1[b]  = raw[b];
      prs[b] = np_prs;
    end
  endtask

  task automatic compare_all();
    bit e_seg, e_min, e_hora, e_blink, inc_ok;
    inc_ok  = prs[1] && !prs[0];
    e_seg   = (m_md == 0) && m_tick;
    e_min   = (m_md == 0) ? (m_tick && im) : ((m_md == 2) ? inc_ok : 1'b0);
    e_hora  = (m_md == 0) ? (m_tick && im && ih) : ((m_md == 1) ? inc_ok : 1'b0);
    e_blink = (m_md == 0) ? 1'b1 : (m_presc < CLK_HZ / 2);
    chk("tick_1hz", int'(tick_1hz), int'(m_tick));
    chk("seg_en",   int'(seg_en),   int'(e_seg));
    chk("min_en",   int'(min_en),   int'(e_min));
    chk("hora_en",  int'(hora_en),  int'(e_hora));
    chk("seg_clr",  int'(seg_clr),  int'(m_clr));
    chk("modo",     int'(modo),     m_md);
    chk("blink",    int'(blink),    int'(e_blink));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    cyc++;
    @(negedge clk);
    compare_all();
    if (tick_1hz) tick_q.push_back(cyc);
    if (seg_en) n_seg++;
    if (min_en) n_min++;
    if (hora_en) n_hora++;
    if (!blink) n_blink0++;
    if (modo != 2'b00) n_modo_nz++;
    if (modo == 2'b01 && first_modo1 < 0) first_modo1 = cyc;
    if (seg_clr) begin
      n_clr++;
      clr_cyc = cyc;
    end
    if (seg_en && clr_cyc >= 0 && seg_after_clr < 0) seg_after_clr = cyc;
  endtask

  task automatic clr_tally();
    n_seg = 0; n_min = 0; n_hora = 0; n_clr = 0; n_blink0 = 0; n_modo_nz = 0;
    first_modo1 = -1; clr_cyc = -1; seg_after_clr = -1;
  endtask

  task automatic press(input int b, input int hold, input int gap);
    if (b == 0) btn_m = 1'b1;
    else btn_i = 1'b1;
    repeat (hold) step();
    if (b == 0) btn_m = 1'b0;
    else btn_i = 1'b0;
    repeat (gap) step();
  endtask

  task automatic chk_reset_values();
    chk("rst_tick", int'(tick_1hz), 0);
    chk("rst_seg_en", int'(seg_en), 0);
    chk("rst_min_en", int'(min_en), 0);
    chk("rst_hora_en", int'(hora_en), 0);
    chk("rst_seg_clr", int'(seg_clr), 0);
    chk("rst_modo", int'(modo), 0);
    chk("rst_blink", int'(blink), 1);
  endtask

  initial begin
    int r;
    model_reset();
    clr_tally();
    #1;
    chk_reset_values();
    repeat (3) step();
    rst_n = 1'b1;
    cyc = 0;
    tick_q.delete();

    // Free-running ticks after reset release.
    repeat (35) step();
    chk("tick_count", tick_q.size(), 3);
    if (tick_q.size() == 3) begin
      chk("tick0_cycle", tick_q[0], 10);
      chk("tick1_cycle", tick_q[1], 20);
      chk("tick2_cycle", tick_q[2], 30);
    end
    chk("run_seg_pulses", n_seg, 3);
    chk("run_min_idle", n_min, 0);
    chk("run_hora_idle", n_hora, 0);

    // Carry chain in RUN.
    clr_tally();
    im = 1'b1; ih = 1'b1;
    repeat (20) step();
    chk("carry_seg", n_seg, 2);
    chk("carry_min", n_min, 2);
    chk("carry_hora", n_hora, 2);
    clr_tally();
    ih = 1'b0;
    repeat (20) step();
    chk("carry_nohr_min", n_min, 2);
    chk("carry_nohr_hora", n_hora, 0);
    im = 1'b0;

    // Held mode button: one press into SET_HORA, then frozen timekeeping.
    clr_tally();
    r = cyc;
    btn_m = 1'b1;
    repeat (10) step();
    btn_m = 1'b0;
    chk("modo01_latency", first_modo1 - r, 8);
    n_seg = 0; n_blink0 = 0;
    repeat (30) step();
    chk("sethora_no_seg", n_seg, 0);
    chk("sethora_blink_off", n_blink0, 15);
    chk("sethora_modo", int'(modo), 1);
    clr_tally();
    press(1, 8, 10);
    press(1, 8, 10);
    chk("sethora_hora2", n_hora, 2);
    chk("sethora_min0", n_min, 0);

    // SET_MIN: three increments, then back to RUN with seconds clear.
    press(0, 8, 10);
    chk("setmin_modo", int'(modo), 2);
    clr_tally();
    repeat (3) press(1, 8, 10);
    chk("setmin_min3", n_min, 3);
    chk("setmin_hora0", n_hora, 0);
    clr_tally();
    press(0, 8, 10);
    repeat (5) step();
    chk("exit_clr_once", n_clr, 1);
    chk("exit_seg_delay", seg_after_clr - clr_cyc, 10);
    chk("exit_modo", int'(modo), 0);

    // Simultaneous mode+inc in SET_HORA, then a short glitch in SET_MIN.
    press(0, 8, 10);
    clr_tally();
    btn_m = 1'b1; btn_i = 1'b1;
    repeat (8) step();
    btn_m = 1'b0; btn_i = 1'b0;
    repeat (10) step();
    chk("simul_modo", int'(modo), 2);
    chk("simul_hora0", n_hora, 0);
    chk("simul_min0", n_min, 0);
    press(1, 2, 12);
    chk("glitch_min0", n_min, 0);

    // Reset in the middle of a mode-button debounce while in SET_MIN.
    btn_m = 1'b1;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_values();
    btn_m = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    clr_tally();
    repeat (20) step();
    chk("stale_no_press", n_modo_nz, 0);
    press(0, 8, 10);
    chk("fresh_press_modo", int'(modo), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/relogio_ctrl.md
# relogio_ctrl

Sequencing and time-setting controller for the clock's counter chain (seconds, minutes, hours machines). It divides the system clock into a 1 Hz tick. In run mode it issues cascaded count enables to the seconds, minutes and hours machines. In set mode it freezes timekeeping and converts debounced pushbutton presses into single increments of the hour or minute field. It sits between the board buttons, the counter machines and the display driver, and supplies the blink signal for the field being edited.

## Interface
- CLK_HZ, 50_000_000, maqs_clock frequency; prescaler terminal count is CLK_HZ-1
- DEB_CYCLES, 1_000_000, cycles a synchronized button level must be stable before it is accepted
- maqs_clock  in  1  system clock, rising edge
- maqs_reset  in  1  reset maqs_reset, asynchronous, active-low; clock maqs_clock
- btn_modo  in  1  mode button, active-high, asynchronous to maqs_clock
- btn_inc  in  1  increment button, active-high, asynchronous
- inc_minuto_in  in  1  seconds machine at 59 (carry out)
- inc_hora_in  in  1  minutes machine at 59 (carry out)
- tick_1hz  out  1  one-cycle pulse every CLK_HZ cycles
- seg_en  out  1  count enable, seconds machine
- min_en  out  1  count enable, minutes machine
- hora_en  out  1  count enable, hours machine
- seg_clr  out  1  one-cycle synchronous clear request, seconds machine
- modo  out  2  state: 00 RUN, 01 SET_HORA, 10 SET_MIN
- blink  out  1  display enable for the edited field; 1 = show

## Operation
- Prescaler:
  - Width $clog2(CLK_HZ); counts 0..CLK_HZ-1 and wraps to 0.
  - tick_1hz is registered and high in the cycle after the prescaler reaches CLK_HZ-1.
- Button path, per button:
  - 2-flop synchronizer, then debounce counter.
  - The debounced level takes the synchronized value once that value has differed from it for DEB_CYCLES consecutive cycles.
  - A registered rising-edge detect then produces one press pulse.
  - A held button produces exactly one pulse. No auto-repeat.
- FSM, three states; 11 is unreachable and recovers to RUN on the next cycle:
  - RUN: modo press -> SET_HORA.
  - SET_HORA: modo press -> SET_MIN.
  - SET_MIN: modo press -> RUN.
  - SET_MIN -> RUN transition: seg_clr pulses for one cycle and the prescaler is reset to 0.
- Enables, combinational from registered state, tick and press pulses:
  - RUN: seg_en = tick_1hz; min_en = tick_1hz & inc_minuto_in; hora_en = tick_1hz & inc_minuto_in & inc_hora_in.
  - SET_HORA: hora_en = inc press; seg_en = min_en = 0.
  - SET_MIN: min_en = inc press; seg_en = hora_en = 0. No carry into hours.
- Prescaler and tick_1hz keep running in set modes; only the enables are suppressed.
- blink:
  - RUN: 1.
  - Set modes: 1 while prescaler < CLK_HZ/2, else 0.
- Simultaneous modo and inc press in the same cycle: modo wins and the inc press is discarded.
- Reset, asynchronous, any time including mid-set:
  - state RUN, prescaler 0, synchronizers/debounce/edge registers 0.
  - tick_1hz, seg_en, min_en, hora_en, seg_clr = 0; modo = 00; blink = 1.

## Timing
- tick_1hz period is exactly CLK_HZ cycles. After reset release, the first tick is CLK_HZ cycles after the first active edge.
- Button-to-pulse latency is DEB_CYCLES+3 cycles from the input rising edge, given a clean input.
- State changes on the edge following the modo press pulse. Enables in the new state apply from the next cycle.
- seg_clr is high in the same cycle that modo changes 10->00. The first RUN tick_1hz arrives CLK_HZ cycles later.
- Every enable is at most one cycle wide. Multiple enables may be high in the same cycle only in RUN via the carry chain.
- A glitch shorter than DEB_CYCLES cycles produces no press.

## Test plan
Bench parameters: CLK_HZ=10, DEB_CYCLES=4.
- Reset release, no buttons, 35 cycles -> tick_1hz and seg_en pulse at cycles 10, 20, 30; min_en and hora_en stay 0; modo=00, blink=1.
- inc_minuto_in=1 and inc_hora_in=1 held in RUN -> seg_en, min_en and hora_en all pulse together on each tick; with inc_hora_in=0 only seg_en and min_en pulse.
- btn_modo high 10 cycles -> single press, modo=01 at cycle 7–8; blink is 1 for prescaler 0–4 and 0 for 5–9; no seg_en for 30 cycles; two btn_inc presses -> exactly two hora_en pulses.
- modo to SET_MIN, three btn_inc presses -> three min_en pulses, hora_en=0; modo press -> seg_clr one cycle, modo=00, next seg_en 10 cycles later.
- btn_modo and btn_inc rising in the same cycle while in SET_HORA -> modo=10, no hora_en or min_en pulse; 2-cycle btn_inc glitch -> no pulse.
- maqs_reset asserted mid-SET_MIN during a debounce -> all outputs at reset values immediately; after release the stale button produces no press until a new stable rising edge.
